// File: rtl/lc3b_write_buffer_pkg.sv
// lc3b_types: write-buffer FSM states and the byte-address to line-address helper
package lc3b_types;
  localparam int ADDR_MAX = 64;
  typedef enum logic {WB_IDLE, WB_WRITE} lc3b_wb_state;
  function automatic logic [ADDR_MAX-1:0] line_of(input logic [ADDR_MAX-1:0] addr, input int offset_w);
    return addr >> offset_w;
  endfunction
endpackage

// File: rtl/lc3b_write_buffer_cam.sv
// lc3b_wb_cam: DEPTH-way line comparator returning the youngest valid match
module lc3b_wb_cam #(
  parameter int DEPTH = 4,
  parameter int LINE_W = 12,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][LINE_W-1:0] line,
  input  logic [LINE_W-1:0]            probe,
  input  logic [PW-1:0]                head,
  output logic [DEPTH-1:0]             match_oh,
  output logic [PW-1:0]                match_idx
);
  logic found;
  // walk oldest to youngest so the last match seen is the youngest
  always_comb begin
    found = 1'b0;
    match_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid[head + PW'(k)] && line[head + PW'(k)] == probe) begin
        found = 1'b1;
        match_idx = head + PW'(k);
      end
    end
    match_oh = found ? (DEPTH'(1) << match_idx) : '0;
  end
endmodule

// File: rtl/lc3b_write_buffer.sv
// lc3b_write_buffer: coalescing dirty-victim FIFO between L1 and memory,
// with read-miss forwarding and a handshaked drain FSM.
module lc3b_write_buffer
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int BLOCK_W = 128,
  parameter int OFFSET_W = 4,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               evict_write,
  input  logic [ADDR_W-1:0]  evict_addr,
  input  logic [BLOCK_W-1:0] evict_data,
  output logic               evict_stall,
  input  logic               lookup_read,
  input  logic [ADDR_W-1:0]  lookup_addr,
  output logic               lookup_hit,
  output logic [BLOCK_W-1:0] lookup_data,
  input  logic               drain_en,
  input  logic               flush_req,
  output logic               flush_done,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic               mem_resp
);
  localparam int LINE_W = ADDR_W - OFFSET_W;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  lc3b_wb_state state_q, state_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0][LINE_W-1:0] line_q, line_d;
  logic [DEPTH-1:0][BLOCK_W-1:0] data_q, data_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [LINE_W-1:0] ev_line, lk_line;
  logic [DEPTH-1:0] co_valid, co_oh, lk_oh;
  logic [PW-1:0] co_idx, lk_idx;
  logic co_hit, lk_hit, push, pop, writing;
  assign ev_line = LINE_W'(line_of(ADDR_MAX'(evict_addr), OFFSET_W));
  assign lk_line = LINE_W'(line_of(ADDR_MAX'(lookup_addr), OFFSET_W));
  assign writing = state_q == WB_WRITE;
  // the head being written to memory is frozen, so it never takes a coalesce
  assign co_valid = valid_q & ~({{(DEPTH-1){1'b0}}, writing} << head_q);
  lc3b_wb_cam #(.DEPTH(DEPTH), .LINE_W(LINE_W)) u_co_cam (
    .valid(co_valid), .line(line_q), .probe(ev_line), .head(head_q),
    .match_oh(co_oh), .match_idx(co_idx)
  );
  lc3b_wb_cam #(.DEPTH(DEPTH), .LINE_W(LINE_W)) u_lk_cam (
    .valid(valid_q), .line(line_q), .probe(lk_line), .head(head_q),
    .match_oh(lk_oh), .match_idx(lk_idx)
  );
  assign co_hit = |co_oh;
  assign lk_hit = |lk_oh;
  assign evict_stall = evict_write && count_q == CW'(DEPTH) && !co_hit;
  assign push = evict_write && !evict_stall;
  assign pop = writing && mem_resp;
  assign lookup_hit = lookup_read && lk_hit;
  assign lookup_data = lookup_hit ? data_q[lk_idx] : '0;
  assign mem_write = writing;
  assign mem_addr = writing ? {line_q[head_q], OFFSET_W'(0)} : '0;
  assign mem_wdata = writing ? data_q[head_q] : '0;
  assign flush_done = flush_req && count_q == '0 && state_q == WB_IDLE;
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    line_d = line_q;
    data_d = data_q;
    head_d = head_q;
    tail_d = tail_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d = head_q + 1'b1;
      state_d = WB_IDLE;
    end else if (!writing && count_q != '0 && (drain_en || flush_req || count_q == CW'(DEPTH))) begin
      state_d = WB_WRITE;
    end
    if (push && co_hit) begin
      data_d[co_idx] = evict_data;
    end else if (push) begin
      valid_d[tail_q] = 1'b1;
      line_d[tail_q] = ev_line;
      data_d[tail_q] = evict_data;
      tail_d = tail_q + 1'b1;
    end
    count_d = count_q + CW'(push && !co_hit) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= WB_IDLE;
      valid_q <= '0;
      line_q <= '0;
      data_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      line_q <= line_d;
      data_q <= data_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
endmodule
